psk_qam_mapper: RTL

Parametrised successor to the fixed QPSK mapper. Accepts a serial bit stream under valid/ready handshake, groups bits into symbols, and maps each symbol to signed I/Q samples. Supports BPSK, QPSK and Gray-coded 16-QAM, selectable per symbol. Sits between the bit source/scrambler and the pulse-shaping filter / DAC interface, with full backpressure on both sides.

---
 rtl/psk_qam_mapper_if.sv | 24 ++
 rtl/psk_qam_mapper.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/psk_qam_mapper_if.sv
// Bit-stream input and I/Q sample output of the PSK/QAM mapper.
// The slave side is the mapper; the master side is the bit source plus the sample sink.
interface psk_qam_mapper_if #(
  parameter int W = 12
);
  logic [1:0]          i_mode;
  logic                i_bit;
  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] o_I;
  logic signed [W-1:0] o_Q;
  logic                o_valid;
  logic                i_ready;

  modport master (
    output i_mode, i_bit, i_valid, i_ready,
    input  o_ready, o_I, o_Q, o_valid
  );

  modport slave (
    input  i_mode, i_bit, i_valid, i_ready,
    output o_ready, o_I, o_Q, o_valid
  );
endinterface

// File: rtl/psk_qam_mapper.sv
// Groups serial bits (MSB first) into BPSK/QPSK/Gray 16-QAM symbols and registers signed I/Q.
// Latency 1 clock from last bit; a single pending slot absorbs one stalled symbol, then o_ready drops.
module psk_qam_mapper #(
  parameter int W       = 12,
  parameter int AMP_PSK = 1447,
  parameter int QAM_L1  = 647,
  parameter int QAM_L3  = 1941
) (
  input logic           clk,
  input logic           rst_n,
  psk_qam_mapper_if.slave bus
);

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;

  localparam logic signed [W-1:0] PSK_P = AMP_PSK[W-1:0];
  localparam logic signed [W-1:0] PSK_N = -PSK_P;
  localparam logic signed [W-1:0] L1_P  = QAM_L1[W-1:0];
  localparam logic signed [W-1:0] L1_N  = -L1_P;
  localparam logic signed [W-1:0] L3_P  = QAM_L3[W-1:0];
  localparam logic signed [W-1:0] L3_N  = -L3_P;

  logic [1:0]          cnt;
  logic [1:0]          mode_lat;
  logic [2:0]          hist;
  logic                pend;
  logic signed [W-1:0] pend_i;
  logic signed [W-1:0] pend_q;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_vld;

  logic [1:0]          in_mode;
  logic [1:0]          cur_mode;
  logic [1:0]          last_idx;
  logic [3:0]          word;
  logic                accept;
  logic                sym_last;
  logic                slot_free;
  logic signed [W-1:0] map_i;
  logic signed [W-1:0] map_q;

  function automatic logic signed [W-1:0] qam_axis(input logic [1:0] g);
    logic signed [W-1:0] v;
    case (g)
      2'b00:   v = L3_N;
      2'b01:   v = L1_N;
      2'b11:   v = L1_P;
      default: v = L3_P;
    endcase
    return v;
  endfunction

  // Reserved mode 3 is folded into QPSK before it is latched, so nothing downstream sees it.
  assign in_mode   = (bus.i_mode == 2'd3) ? MODE_QPSK : bus.i_mode;
  assign cur_mode  = (cnt == 2'd0) ? in_mode : mode_lat;
  assign accept    = bus.i_valid && bus.o_ready;
  assign word      = {hist, bus.i_bit};
  assign slot_free = !out_vld || bus.i_ready;
  assign sym_last  = accept && (cnt == last_idx);

  always_comb begin
    last_idx = 2'd1;
    case (cur_mode)
      MODE_BPSK:  last_idx = 2'd0;
      MODE_QAM16: last_idx = 2'd3;
      default:    last_idx = 2'd1;
    endcase
  end

  always_comb begin
    map_i = '0;
    map_q = '0;
    case (cur_mode)
      MODE_BPSK: begin
        map_i = word[0] ? PSK_P : PSK_N;
        map_q = '0;
      end
      MODE_QAM16: begin
        map_i = qam_axis(word[3:2]);
        map_q = qam_axis(word[1:0]);
      end
      default: begin
        map_i = word[1] ? PSK_P : PSK_N;
        map_q = word[0] ? PSK_P : PSK_N;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      mode_lat <= MODE_QPSK;
      hist     <= 3'd0;
      pend     <= 1'b0;
      pend_i   <= '0;
      pend_q   <= '0;
      out_i    <= '0;
      out_q    <= '0;
      out_vld  <= 1'b0;
    end else begin
      if (accept) begin
        hist <= word[2:0];
        cnt  <= sym_last ? 2'd0 : cnt + 2'd1;
        if (cnt == 2'd0) begin
          mode_lat <= in_mode;
        end
      end

      // A pending symbol blocks new bits, so it and a fresh last bit never compete for the slot.
      if (pend && slot_free) begin
        out_i   <= pend_i;
        out_q   <= pend_q;
        out_vld <= 1'b1;
        pend    <= 1'b0;
      end else if (sym_last && slot_free) begin
        out_i   <= map_i;
        out_q   <= map_q;
        out_vld <= 1'b1;
      end else begin
        if (sym_last) begin
          pend   <= 1'b1;
          pend_i <= map_i;
          pend_q <= map_q;
        end
        if (out_vld && bus.i_ready) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign bus.o_ready = rst_n && !pend;
  assign bus.o_I     = out_i;
  assign bus.o_Q     = out_q;
  assign bus.o_valid = out_vld;

endmodule
